rand_uart_tx: RTL and testbench

RAND_UART_TX -- requirements
Module: rand_uart_tx

---
 rtl/uart_pkg.sv | 11 +
 rtl/baud_gen.sv | 15 +
 rtl/rand_uart_tx.sv | 119 +++++++++++
 tb/tb_rand_uart_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and frame sizing shared by rand_uart_tx.
// Frame size depends on UART_PARITY_EN (adds an even-parity bit).
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int DATA_BITS = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
endpackage

// File: rtl/baud_gen.sv
// baud_gen: bit-period counter; tick_o marks the last cycle of each BaudDiv-cycle bit.
module baud_gen #(
  parameter int BaudDiv = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  logic [15:0] r_cnt;
  assign tick_o = r_cnt == 16'(BaudDiv - 1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_cnt <= '0;
    else r_cnt <= (clr_i || tick_o) ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/rand_uart_tx.sv
// rand_uart_tx: byte FIFO feeding an 8N1 UART transmitter for the chaotic RNG output.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module rand_uart_tx
  import uart_pkg::*;
#(
  parameter int BaudDiv = 434,
  parameter int Depth   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int PW = $clog2(Depth);
  localparam logic [PW:0] FULL = (PW + 1)'(Depth);
  logic [7:0]    r_mem [Depth];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  state_e        r_state, w_state_nxt;
  logic [7:0]    r_shift;
  logic [3:0]    r_bit_idx;
  logic          r_tx, w_tx_nxt, w_push, w_pop, w_tick, w_shift;
`ifdef UART_PARITY_EN
  logic          r_par;
`endif
  assign ready_o = r_count < FULL;
  assign w_push  = valid_i && ready_o;
  assign busy_o  = (r_state != IDLE) || (r_count != '0);
  assign tx_o    = r_tx;
  baud_gen #(.BaudDiv(BaudDiv)) u_baud (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_pop),
    .tick_o(w_tick)
  );
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // tx is registered from the next-state decision so it changes on the same edge as the state
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE:
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      START:
        if (w_tick) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      DATA:
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_bit_idx == 4'(DATA_BITS)) begin
`ifdef UART_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else w_tx_nxt = r_shift[1];
        end
      PARITY:
        if (w_tick) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
      STOP:
        if (w_tick && r_bit_idx == 4'(FRAME_BITS - 1)) begin
          w_pop       = r_count != '0;
          w_state_nxt = w_pop ? START : IDLE;
          w_tx_nxt    = !w_pop;
        end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else begin
      r_tx <= w_tx_nxt;
      if (w_pop) begin
        r_shift   <= r_mem[r_rd_ptr];
        r_bit_idx <= '0;
      end else begin
        if (w_shift) r_shift <= r_shift >> 1;
        if (w_tick && r_state != IDLE) r_bit_idx <= r_bit_idx + 4'd1;
      end
    end
`ifdef UART_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_par <= 1'b0;
    else if (w_pop) r_par <= ^r_mem[r_rd_ptr];
`endif
endmodule

// File: tb/tb_rand_uart_tx.sv
// tb_rand_uart_tx: directed stimulus with a byte scoreboard decoded from the serial line.
module tb_rand_uart_tx;
  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * BAUD;
  logic       clk_i   = 1'b0;
  logic       rst_i   = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] data_i  = 8'h00;
  logic       ready_o, tx_o, busy_o;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  logic       mon_abort = 1'b0;
  logic [7:0] fill [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  rand_uart_tx #(.BaudDiv(BAUD), .Depth(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // called at a negedge; returns at the negedge following the accepting edge
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (!ready_o && n < 4 * FL) begin
      @(negedge clk_i);
      n++;
    end
    check("push_accept", ready_o, 1);
    if (ready_o) sb.push_back(b);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy_o && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_reached", busy_o, 0);
  endtask

  task automatic send_single(input logic [7:0] b);
    logic [10:0] f;
    int cyc = 0;
    f = frame(b);
    push_byte(b);
    check($sformatf("tx_no_early_fall_%02h", b), tx_o, 1);
    @(negedge clk_i);
    check($sformatf("tx_fall_1cyc_%02h", b), tx_o, 0);
    while (busy_o && cyc < 4 * FL) begin
      if (cyc % BAUD == BAUD / 2)
        check($sformatf("line_bit%0d_%02h", cyc / BAUD, b), tx_o, f[cyc/BAUD]);
      @(negedge clk_i);
      cyc++;
    end
    check($sformatf("frame_len_%02h", b), cyc, FL);
  endtask

  always @(negedge rst_i) mon_abort = 1'b1;

  initial forever begin
    logic [7:0] b;
    logic       s0, s1;
`ifdef UART_PARITY_EN
    logic       p;
`endif
    @(negedge clk_i);
    if (rst_i && tx_o === 1'b0) begin
      mon_abort = 1'b0;
      repeat (BAUD / 2) @(negedge clk_i);
      s0 = tx_o;
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk_i);
        b[i] = tx_o;
      end
`ifdef UART_PARITY_EN
      repeat (BAUD) @(negedge clk_i);
      p = tx_o;
`endif
      repeat (BAUD) @(negedge clk_i);
      s1 = tx_o;
      if (!mon_abort) begin
        check("mon_start_bit", s0, 0);
        check("mon_stop_bit", s1, 1);
`ifdef UART_PARITY_EN
        check("mon_parity_bit", p, ^b);
`endif
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_frame: got %02h expected no frame", b);
        end else check("mon_byte", b, sb.pop_front());
      end
    end
  end

  initial begin
    int   cyc;
    logic saw_low;
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_tx", tx_o, 1);
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check("idle_tx", tx_o, 1);
    check("idle_busy", busy_o, 0);

    send_single(8'hA5);
    send_single(8'h07);
    send_single(8'h03);

    push_byte(8'h00);
    push_byte(8'hFF);
    cyc = 0;
    while (busy_o && cyc < 6 * FL) begin
      if (cyc == FL - 1) check("b2b_first_stop", tx_o, 1);
      if (cyc == FL) check("b2b_second_start", tx_o, 0);
      @(negedge clk_i);
      cyc++;
    end
    check("b2b_total_len", cyc, 2 * FL);

    for (int i = 0; i < 6; i++) begin
      push_byte(fill[i]);
      if (i == 3) check("ready_with_4_held", ready_o, 1);
      if (i == 4) check("ready_full_5_held", ready_o, 0);
    end
    wait_idle(10 * FL);

    push_byte(8'hA5);
    push_byte(8'hC3);
    repeat (17) @(negedge clk_i);
    check("pre_rst_data_bit3", tx_o, 0);
    rst_i = 1'b0;
    #1;
    check("midrst_tx", tx_o, 1);
    check("midrst_ready", ready_o, 1);
    check("midrst_busy", busy_o, 0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_i   = 1'b1;
    saw_low = 1'b0;
    repeat (3 * FL) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) saw_low = 1'b1;
    end
    check("no_resend_after_rst", saw_low, 0);
    check("post_rst_busy", busy_o, 0);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
